// File: rtl/exe_stage_md_pkg.sv
// Shared encodings for the execute stage: ALU control codes, forwarding selects
// and the mul/div sequencer state and operation types.
package exe_pkg;

  localparam int unsigned ALU_SLL   = 'h00;
  localparam int unsigned ALU_SRL   = 'h02;
  localparam int unsigned ALU_SRA   = 'h03;
  localparam int unsigned ALU_MFHI  = 'h10;
  localparam int unsigned ALU_MTHI  = 'h11;
  localparam int unsigned ALU_MFLO  = 'h12;
  localparam int unsigned ALU_MTLO  = 'h13;
  localparam int unsigned ALU_MULT  = 'h18;
  localparam int unsigned ALU_MULTU = 'h19;
  localparam int unsigned ALU_DIV   = 'h1A;
  localparam int unsigned ALU_DIVU  = 'h1B;
  localparam int unsigned ALU_ADD   = 'h20;
  localparam int unsigned ALU_SUB   = 'h22;
  localparam int unsigned ALU_AND   = 'h24;
  localparam int unsigned ALU_OR    = 'h25;
  localparam int unsigned ALU_XOR   = 'h26;
  localparam int unsigned ALU_NOR   = 'h27;
  localparam int unsigned ALU_SLT   = 'h2A;
  localparam int unsigned ALU_SLTU  = 'h2B;

  localparam logic [1:0] FWD_REG    = 2'd0;
  localparam logic [1:0] FWD_MEM    = 2'd1;
  localparam logic [1:0] FWD_EX     = 2'd2;
  localparam logic [1:0] FWD_EX_ALT = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

endpackage

// File: rtl/exe_stage_md_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface exe_stage_md_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned CTRL_BITS = 6
);
  logic                 in_valid, in_ready, flush;
  logic [31:0]          instr_in, pc_in;
  logic [XLEN-1:0]      op_a_in, op_b_in, mem_fwd_data, mem_wdata_in;
  logic [1:0]           fwd_a, fwd_b;
  logic [4:0]           shamt_in;
  logic [CTRL_BITS-1:0] alu_ctrl_in;
  logic [REG_BITS-1:0]  wreg_in;
  logic                 reg_write_in, mem_read_in, mem_write_in;

  logic                 out_valid;
  logic [31:0]          instr_out, pc_out;
  logic [XLEN-1:0]      result_out, mem_wdata_out, hi_out, lo_out;
  logic [REG_BITS-1:0]  wreg_out;
  logic                 reg_write_out, mem_read_out, mem_write_out;
  logic [CTRL_BITS-1:0] alu_ctrl_out;
  logic                 md_busy;

  modport slave (
    input  in_valid, flush, instr_in, pc_in, op_a_in, op_b_in, fwd_a, fwd_b, mem_fwd_data,
           shamt_in, alu_ctrl_in, wreg_in, reg_write_in, mem_read_in, mem_write_in, mem_wdata_in,
    output in_ready, out_valid, instr_out, pc_out, result_out, wreg_out, reg_write_out,
           mem_read_out, mem_write_out, mem_wdata_out, alu_ctrl_out, hi_out, lo_out, md_busy
  );

  modport master (
    output in_valid, flush, instr_in, pc_in, op_a_in, op_b_in, fwd_a, fwd_b, mem_fwd_data,
           shamt_in, alu_ctrl_in, wreg_in, reg_write_in, mem_read_in, mem_write_in, mem_wdata_in,
    input  in_ready, out_valid, instr_out, pc_out, result_out, wreg_out, reg_write_out,
           mem_read_out, mem_write_out, mem_wdata_out, alu_ctrl_out, hi_out, lo_out, md_busy
  );
endinterface

// File: rtl/exe_stage_md_md_unit.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes with a final sign fix.
// Occupies XLEN BUSY cycles plus one DONE cycle, during which hi/lo are valid.
module md_unit
  import exe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int unsigned CW = $clog2(XLEN);

  md_state_t       state_q, state_d;
  md_op_t          op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, q, mcand, a_q;
  logic            neg_q, neg_r, b_zero;

  logic            start_div, start_signed, a_neg, b_neg, is_div;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem;
  logic [XLEN:0]   mul_sum, div_sh, div_trial;
  logic [2*XLEN-1:0] prod;

  assign start_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign start_signed = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg        = start_signed & a[XLEN-1];
  assign b_neg        = start_signed & b[XLEN-1];
  assign mag_a        = a_neg ? -a : a;
  assign mag_b        = b_neg ? -b : b;
  assign is_div       = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // Multiply: acc:q is the shifting product, q holds the multiplier.
  // Divide: acc is the partial remainder, q shifts dividend out and quotient in.
  assign mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, mcand} : '0);
  assign div_sh    = {acc, q[XLEN-1]};
  assign div_trial = div_sh - {1'b0, mcand};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      cnt     <= '0;
      acc     <= '0;
      q       <= '0;
      mcand   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          op_q   <= op;
          a_q    <= a;
          b_zero <= (b == '0);
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt    <= '0;
          acc    <= '0;
          q      <= start_div ? mag_a : mag_b;
          mcand  <= start_div ? mag_b : mag_a;
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc <= div_trial[XLEN] ? div_sh[XLEN-1:0] : div_trial[XLEN-1:0];
            q   <= {q[XLEN-2:0], ~div_trial[XLEN]};
          end else begin
            acc <= mul_sum[XLEN:1];
            q   <= {mul_sum[0], q[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt == CW'(XLEN-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    prod = {acc, q};
    if (neg_q) prod = -prod;
    quo  = neg_q ? -q : q;
    rem  = neg_r ? -acc : acc;
    if (is_div) begin
      hi = b_zero ? a_q : rem;
      lo = b_zero ? '1  : quo;
    end else begin
      hi = prod[2*XLEN-1:XLEN];
      lo = prod[XLEN-1:0];
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU, HI/LO ownership and the EX/MEM register.
// Multiply/divide instructions are handed to md_unit and retire from its DONE cycle.
module exe_stage_md
  import exe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned CTRL_BITS = 6
) (
  input logic            CLK,
  input logic            RESET,
  exe_stage_md_if.slave  bus
);
  logic [XLEN-1:0]      op_a, op_b, alu_res, hi_q, lo_q, md_hi, md_lo;
  logic                 is_md, accept, md_start, md_done, md_retire, md_busy_w;
  logic                 is_mthi, is_mtlo;
  md_op_t               md_op;
  logic [31:0]          md_instr, md_pc;
  logic [REG_BITS-1:0]  md_wreg;
  logic                 md_rw;
  logic [CTRL_BITS-1:0] md_ctrl;

  assign bus.in_ready = !md_busy_w;
  assign bus.md_busy  = md_busy_w;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign accept       = bus.in_valid & bus.in_ready & !bus.flush;
  assign md_start     = accept & is_md;
  assign md_retire    = md_done & !bus.flush;

  always_comb begin
    case (bus.fwd_a)
      FWD_REG: op_a = bus.op_a_in;
      FWD_MEM: op_a = bus.mem_fwd_data;
      default: op_a = bus.result_out;
    endcase
    case (bus.fwd_b)
      FWD_REG: op_b = bus.op_b_in;
      FWD_MEM: op_b = bus.mem_fwd_data;
      default: op_b = bus.result_out;
    endcase
  end

  always_comb begin
    alu_res = '0;
    is_md   = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    md_op   = MD_MULT;
    case (bus.alu_ctrl_in)
      CTRL_BITS'(ALU_ADD):   alu_res = op_a + op_b;
      CTRL_BITS'(ALU_SUB):   alu_res = op_a - op_b;
      CTRL_BITS'(ALU_AND):   alu_res = op_a & op_b;
      CTRL_BITS'(ALU_OR):    alu_res = op_a | op_b;
      CTRL_BITS'(ALU_XOR):   alu_res = op_a ^ op_b;
      CTRL_BITS'(ALU_NOR):   alu_res = ~(op_a | op_b);
      CTRL_BITS'(ALU_SLT):   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      CTRL_BITS'(ALU_SLTU):  alu_res = XLEN'(op_a < op_b);
      CTRL_BITS'(ALU_SLL):   alu_res = op_b << bus.shamt_in;
      CTRL_BITS'(ALU_SRL):   alu_res = op_b >> bus.shamt_in;
      CTRL_BITS'(ALU_SRA):   alu_res = $signed(op_b) >>> bus.shamt_in;
      CTRL_BITS'(ALU_MFHI):  alu_res = hi_q;
      CTRL_BITS'(ALU_MFLO):  alu_res = lo_q;
      CTRL_BITS'(ALU_MTHI):  begin alu_res = op_a; is_mthi = 1'b1; end
      CTRL_BITS'(ALU_MTLO):  begin alu_res = op_a; is_mtlo = 1'b1; end
      CTRL_BITS'(ALU_MULT):  begin is_md = 1'b1; md_op = MD_MULT;  end
      CTRL_BITS'(ALU_MULTU): begin is_md = 1'b1; md_op = MD_MULTU; end
      CTRL_BITS'(ALU_DIV):   begin is_md = 1'b1; md_op = MD_DIV;   end
      CTRL_BITS'(ALU_DIVU):  begin is_md = 1'b1; md_op = MD_DIVU;  end
      default: ;
    endcase
  end

  md_unit #(.XLEN(XLEN)) u_md (
    .CLK   (CLK),
    .RESET (RESET),
    .start (md_start),
    .op    (md_op),
    .a     (op_a),
    .b     (op_b),
    .abort (bus.flush),
    .busy  (md_busy_w),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_retire) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (accept) begin
      if (is_mthi) hi_q <= op_a;
      if (is_mtlo) lo_q <= op_a;
    end
  end

  // Mul/div instructions are parked here until DONE, since EX/MEM carries bubbles meanwhile.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      md_instr <= '0;
      md_pc    <= '0;
      md_wreg  <= '0;
      md_rw    <= 1'b0;
      md_ctrl  <= '0;
    end else if (md_start) begin
      md_instr <= bus.instr_in;
      md_pc    <= bus.pc_in;
      md_wreg  <= bus.wreg_in;
      md_rw    <= bus.reg_write_in;
      md_ctrl  <= bus.alu_ctrl_in;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.out_valid     <= 1'b0;
      bus.instr_out     <= '0;
      bus.pc_out        <= '0;
      bus.result_out    <= '0;
      bus.wreg_out      <= '0;
      bus.reg_write_out <= 1'b0;
      bus.mem_read_out  <= 1'b0;
      bus.mem_write_out <= 1'b0;
      bus.mem_wdata_out <= '0;
      bus.alu_ctrl_out  <= '0;
    end else if (accept && !is_md) begin
      bus.out_valid     <= 1'b1;
      bus.instr_out     <= bus.instr_in;
      bus.pc_out        <= bus.pc_in;
      bus.result_out    <= alu_res;
      bus.wreg_out      <= bus.wreg_in;
      bus.reg_write_out <= bus.reg_write_in;
      bus.mem_read_out  <= bus.mem_read_in;
      bus.mem_write_out <= bus.mem_write_in;
      bus.mem_wdata_out <= bus.mem_wdata_in;
      bus.alu_ctrl_out  <= bus.alu_ctrl_in;
    end else if (md_retire) begin
      bus.out_valid     <= 1'b1;
      bus.instr_out     <= md_instr;
      bus.pc_out        <= md_pc;
      bus.wreg_out      <= md_wreg;
      bus.reg_write_out <= md_rw;
      bus.mem_read_out  <= 1'b0;
      bus.mem_write_out <= 1'b0;
      bus.alu_ctrl_out  <= md_ctrl;
    end else begin
      bus.out_valid     <= 1'b0;
      bus.instr_out     <= '0;
      bus.reg_write_out <= 1'b0;
      bus.mem_read_out  <= 1'b0;
      bus.mem_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md at XLEN=32: ALU, forwarding, mul/div, flush and reset.
module tb_exe_stage_md;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   tests = 0;
  int   fails = 0;

  exe_stage_md_if #(.XLEN(32), .REG_BITS(5), .CTRL_BITS(6)) bus ();

  exe_stage_md #(.XLEN(32), .REG_BITS(5), .CTRL_BITS(6)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  c;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  task automatic drive(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] sh);
    bus.in_valid     = 1'b1;
    bus.alu_ctrl_in  = c;
    bus.instr_in     = 32'hC000_0000 | {26'd0, c};
    bus.pc_in        = 32'h0000_1000 + {26'd0, c};
    bus.op_a_in      = a;
    bus.op_b_in      = b;
    bus.fwd_a        = fa;
    bus.fwd_b        = fb;
    bus.shamt_in     = sh;
    bus.wreg_in      = 5'd3;
    bus.reg_write_in = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic wait_md(output int low);
    low = 0;
    while (!bus.in_ready && low < 100) begin
      low++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %h want 1", bus.in_ready); end
    tests++; if (bus.md_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %h want 0", bus.md_busy); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %h want 0", bus.out_valid); end
    tests++; if (bus.result_out !== 32'h0) begin fails++; $display("FAIL rst_result got %h want 0", bus.result_out); end
    tests++; if ({bus.hi_out, bus.lo_out} !== 64'h0) begin fails++; $display("FAIL rst_hilo got %h want 0", {bus.hi_out, bus.lo_out}); end
    RESET = 1'b1;
    step();
  endtask

  task automatic test_add();
    drive(6'h20, 32'h7FFF_FFFF, 32'h1, 2'd0, 2'd0, 5'd0);
    step();
    tests++; if (bus.result_out !== 32'h8000_0000) begin fails++; $display("FAIL add_ovf got %h want 80000000", bus.result_out); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %h want 1", bus.out_valid); end
    tests++; if ({bus.wreg_out, bus.reg_write_out, bus.alu_ctrl_out} !== {5'd3, 1'b1, 6'h20}) begin
      fails++; $display("FAIL add_ctrl got %h want %h", {bus.wreg_out, bus.reg_write_out, bus.alu_ctrl_out}, {5'd3, 1'b1, 6'h20}); end
    tests++; if (bus.instr_out !== 32'hC000_0020) begin fails++; $display("FAIL add_instr got %h want c0000020", bus.instr_out); end
    step();
    tests++; if ({bus.out_valid, bus.reg_write_out, bus.instr_out} !== 34'h0) begin
      fails++; $display("FAIL bubble got %h want 0", {bus.out_valid, bus.reg_write_out, bus.instr_out}); end
    tests++; if (bus.result_out !== 32'h8000_0000) begin fails++; $display("FAIL bubble_hold got %h want 80000000", bus.result_out); end
  endtask

  task automatic test_forwarding();
    drive(6'h20, 32'd5, 32'd3, 2'd0, 2'd0, 5'd0);
    step();
    drive(6'h20, 32'hDEAD, 32'd1, 2'd2, 2'd0, 5'd0);
    step();
    tests++; if (bus.result_out !== 32'd9) begin fails++; $display("FAIL fwd_ex got %h want 9", bus.result_out); end
    bus.mem_fwd_data = 32'h10;
    drive(6'h20, 32'h20, 32'h99, 2'd0, 2'd1, 5'd0);
    step();
    tests++; if (bus.result_out !== 32'h30) begin fails++; $display("FAIL fwd_mem got %h want 30", bus.result_out); end
    drive(6'h20, 32'h1, 32'h1, 2'd3, 2'd3, 5'd0);
    step();
    tests++; if (bus.result_out !== 32'h60) begin fails++; $display("FAIL fwd_ex3 got %h want 60", bus.result_out); end
  endtask

  task automatic test_alu_ops();
    vec_t v[9];
    v[0] = '{6'h22, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE};
    v[1] = '{6'h24, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0,  32'h00F0_F000};
    v[2] = '{6'h27, 32'hF0F0_0000, 32'h0000_000F, 5'd0,  32'h0F0F_FFF0};
    v[3] = '{6'h2A, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1};
    v[4] = '{6'h2B, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0};
    v[5] = '{6'h03, 32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000};
    v[6] = '{6'h00, 32'd0,         32'd1,         5'd31, 32'h8000_0000};
    v[7] = '{6'h02, 32'd0,         32'h8000_0000, 5'd31, 32'd1};
    v[8] = '{6'h3F, 32'd5,         32'd6,         5'd0,  32'd0};
    for (int i = 0; i < 9; i++) begin
      drive(v[i].c, v[i].a, v[i].b, 2'd0, 2'd0, v[i].sh);
      step();
      tests++; if (bus.result_out !== v[i].exp) begin
        fails++; $display("FAIL alu_op%0h got %h want %h", v[i].c, bus.result_out, v[i].exp); end
    end
    tests++; if ({bus.out_valid, bus.alu_ctrl_out} !== {1'b1, 6'h3F}) begin
      fails++; $display("FAIL undef_pass got %h want %h", {bus.out_valid, bus.alu_ctrl_out}, {1'b1, 6'h3F}); end
  endtask

  task automatic test_mult();
    int low;
    drive(6'h18, 32'hFFFF_FFFD, 32'd7, 2'd0, 2'd0, 5'd0);
    step();
    tests++; if ({bus.md_busy, bus.out_valid} !== 2'b10) begin
      fails++; $display("FAIL mult_start got %b want 10", {bus.md_busy, bus.out_valid}); end
    wait_md(low);
    tests++; if (low !== 33) begin fails++; $display("FAIL mult_cycles got %0d want 33", low); end
    tests++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      fails++; $display("FAIL mult_hilo got %h want ffffffffffffffeb", {bus.hi_out, bus.lo_out}); end
    tests++; if ({bus.out_valid, bus.reg_write_out, bus.instr_out} !== {1'b1, 1'b1, 32'hC000_0018}) begin
      fails++; $display("FAIL mult_retire got %h want %h", {bus.out_valid, bus.reg_write_out, bus.instr_out}, {1'b1, 1'b1, 32'hC000_0018}); end
    drive(6'h12, 32'd0, 32'd0, 2'd0, 2'd0, 5'd0);
    step();
    tests++; if (bus.result_out !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mflo got %h want ffffffeb", bus.result_out); end
    drive(6'h10, 32'd0, 32'd0, 2'd0, 2'd0, 5'd0);
    step();
    tests++; if (bus.result_out !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mfhi got %h want ffffffff", bus.result_out); end
  endtask

  task automatic test_div();
    int low;
    vec_t v[5];
    v[0] = '{6'h1A, 32'hFFFF_FFF9, 32'd2,         5'd0, 32'hFFFF_FFFD};
    v[1] = '{6'h1B, 32'd5,         32'd0,         5'd0, 32'hFFFF_FFFF};
    v[2] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000};
    v[3] = '{6'h19, 32'hFFFF_FFFF, 32'd2,         5'd0, 32'hFFFF_FFFE};
    v[4] = '{6'h1A, 32'd7,         32'hFFFF_FFFE, 5'd0, 32'hFFFF_FFFD};
    // expected HI per vector in the sh-independent field below
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_hi;
      case (i)
        0: exp_hi = 32'hFFFF_FFFF;
        1: exp_hi = 32'd5;
        2: exp_hi = 32'd0;
        3: exp_hi = 32'd1;
        default: exp_hi = 32'd1;
      endcase
      drive(v[i].c, v[i].a, v[i].b, 2'd0, 2'd0, 5'd0);
      step();
      wait_md(low);
      tests++; if ({bus.hi_out, bus.lo_out} !== {exp_hi, v[i].exp}) begin
        fails++; $display("FAIL md_vec%0d got %h want %h", i, {bus.hi_out, bus.lo_out}, {exp_hi, v[i].exp}); end
    end
  endtask

  task automatic test_flush();
    int low;
    drive(6'h11, 32'h1234, 32'd0, 2'd0, 2'd0, 5'd0);
    step();
    drive(6'h13, 32'h5678, 32'd0, 2'd0, 2'd0, 5'd0);
    step();
    tests++; if ({bus.hi_out, bus.lo_out} !== 64'h0000_1234_0000_5678) begin
      fails++; $display("FAIL mthi_mtlo got %h want 0000123400005678", {bus.hi_out, bus.lo_out}); end
    drive(6'h1B, 32'd100, 32'd3, 2'd0, 2'd0, 5'd0);
    step();
    repeat (9) @(posedge CLK);
    #1;
    drive(6'h20, 32'd1, 32'd1, 2'd0, 2'd0, 5'd0);
    bus.flush = 1'b1;
    step();
    tests++; if ({bus.md_busy, bus.in_ready, bus.out_valid, bus.instr_out} !== {3'b010, 32'h0}) begin
      fails++; $display("FAIL flush_busy got %h want %h", {bus.md_busy, bus.in_ready, bus.out_valid, bus.instr_out}, {3'b010, 32'h0}); end
    repeat (40) step();
    wait_md(low);
    tests++; if ({bus.hi_out, bus.lo_out} !== 64'h0000_1234_0000_5678) begin
      fails++; $display("FAIL flush_hilo got %h want 0000123400005678", {bus.hi_out, bus.lo_out}); end
    drive(6'h20, 32'd9, 32'd9, 2'd0, 2'd0, 5'd0);
    step();
    drive(6'h20, 32'd1, 32'd1, 2'd0, 2'd0, 5'd0);
    bus.flush = 1'b1;
    step();
    tests++; if ({bus.out_valid, bus.in_ready, bus.result_out} !== {2'b01, 32'd18}) begin
      fails++; $display("FAIL flush_idle got %h want %h", {bus.out_valid, bus.in_ready, bus.result_out}, {2'b01, 32'd18}); end
  endtask

  task automatic test_reset_mid();
    drive(6'h18, 32'd3, 32'd5, 2'd0, 2'd0, 5'd0);
    step();
    repeat (5) @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    tests++; if ({bus.in_ready, bus.md_busy, bus.out_valid} !== 3'b100) begin
      fails++; $display("FAIL rstmid_ctrl got %b want 100", {bus.in_ready, bus.md_busy, bus.out_valid}); end
    tests++; if ({bus.hi_out, bus.lo_out, bus.result_out, bus.pc_out} !== 128'h0) begin
      fails++; $display("FAIL rstmid_data got %h want 0", {bus.hi_out, bus.lo_out, bus.result_out, bus.pc_out}); end
    @(negedge CLK);
    RESET = 1'b1;
    step();
    drive(6'h20, 32'd1, 32'd1, 2'd0, 2'd0, 5'd0);
    step();
    tests++; if ({bus.out_valid, bus.result_out, bus.lo_out} !== {1'b1, 32'd2, 32'd0}) begin
      fails++; $display("FAIL rstmid_recover got %h want %h", {bus.out_valid, bus.result_out, bus.lo_out}, {1'b1, 32'd2, 32'd0}); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.instr_in = '0; bus.pc_in = '0;
    bus.op_a_in = '0; bus.op_b_in = '0; bus.fwd_a = '0; bus.fwd_b = '0;
    bus.mem_fwd_data = '0; bus.shamt_in = '0; bus.alu_ctrl_in = '0; bus.wreg_in = '0;
    bus.reg_write_in = 1'b0; bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0; bus.mem_wdata_in = '0;
    #12;
    test_reset();
    test_add();
    test_forwarding();
    test_alu_ops();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
